// File: rtl/ps2_host.sv
// PS/2 host: receives device frames into a FIFO and sends host-to-device commands.
// Covers clock inhibit, request-to-send, ACK sampling and per-edge frame timeouts.
module ps2_host #(
  parameter int FIFO_DEPTH     = 8,
  parameter int INHIBIT_CYCLES = 1200,
  parameter int TIMEOUT_CYCLES = 24000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ps2_clk,
  input  logic                            ps2_data,
  output logic                            ps2_clk_pulldown,
  output logic                            ps2_data_pulldown,
  output logic [7:0]                      rx_data,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_count,
  input  logic [7:0]                      tx_data,
  input  logic                            tx_valid,
  output logic                            tx_ready,
  input  logic                            kb_reset_req,
  output logic                            tx_done,
  output logic                            tx_err,
  output logic                            err_parity,
  output logic                            err_frame,
  output logic                            err_timeout,
  output logic                            rx_overflow
);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int TMAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [CW-1:0] DEPTH_C      = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, RX, TX_INHIBIT, TX_RTS, TX_DATA, TX_ACK, TX_WAIT} state_e;

  state_e        state_q, state_d;
  logic [1:0]    clk_sync_q, data_sync_q;
  logic          clk_prev_q;
  logic          clk_s, data_s, fall;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    rx_sr_q, rx_sr_d;
  logic          rx_par_q, rx_par_d;
  logic [9:0]    tx_sr_q, tx_sr_d;
  logic          tx_bit_q, tx_bit_d;
  logic          kb_pend_q, kb_pend_d;
  logic          clk_pd_q, clk_pd_d, data_pd_q, data_pd_d;
  logic          tx_done_q, tx_done_d, tx_err_q, tx_err_d;
  logic          err_par_q, err_par_d, err_frm_q, err_frm_d, err_to_q, err_to_d;
  logic          tx_start;
  logic [7:0]    tx_byte;
  logic          push_req, push, pop, full;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;

  // Lines idle high, so the synchronisers reset to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];
  assign fall   = clk_prev_q & ~clk_s;

  assign tx_ready = (state_q == IDLE) && !kb_pend_q && !kb_reset_req && !rst;
  assign tx_start = kb_pend_q || (tx_valid && tx_ready);
  assign tx_byte  = kb_pend_q ? 8'hFF : tx_data;

  always_comb begin
    state_d   = state_q;
    timer_d   = '0;
    bit_cnt_d = bit_cnt_q;
    rx_sr_d   = rx_sr_q;
    rx_par_d  = rx_par_q;
    tx_sr_d   = tx_sr_q;
    tx_bit_d  = tx_bit_q;
    kb_pend_d = kb_pend_q | kb_reset_req;
    tx_done_d = 1'b0;
    tx_err_d  = 1'b0;
    err_par_d = 1'b0;
    err_frm_d = 1'b0;
    err_to_d  = 1'b0;
    push_req  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_start) begin
          state_d   = TX_INHIBIT;
          tx_sr_d   = {1'b1, ~^tx_byte, tx_byte};
          bit_cnt_d = '0;
          kb_pend_d = kb_reset_req;
        end else if (fall && !data_s) begin
          state_d   = RX;
          bit_cnt_d = '0;
        end
      end
      RX: begin
        if (fall) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q < 4'd8) begin
            rx_sr_d = {data_s, rx_sr_q[7:1]};
          end else if (bit_cnt_q == 4'd8) begin
            rx_par_d = data_s;
          end else begin
            state_d = IDLE;
            if (!(^{rx_sr_q, rx_par_q})) err_par_d = 1'b1;
            else if (!data_s)            err_frm_d = 1'b1;
            else                         push_req  = 1'b1;
          end
        end else if (timer_q == TIMEOUT_LAST) begin
          state_d  = IDLE;
          err_to_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      TX_INHIBIT: begin
        if (timer_q == INHIBIT_LAST) state_d = TX_RTS;
        else                         timer_d = timer_q + 1'b1;
      end
      TX_RTS: begin
        state_d  = TX_DATA;
        tx_bit_d = 1'b0;
      end
      TX_DATA: begin
        // Stop bit is the trailing 1 of tx_sr; driving it releases the line.
        if (fall) begin
          tx_bit_d  = tx_sr_q[0];
          tx_sr_d   = {1'b1, tx_sr_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd9) state_d = TX_ACK;
        end else if (timer_q == TIMEOUT_LAST) begin
          state_d  = IDLE;
          err_to_d = 1'b1;
          tx_err_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      TX_ACK: begin
        if (fall) begin
          state_d = TX_WAIT;
          if (data_s) tx_err_d  = 1'b1;
          else        tx_done_d = 1'b1;
        end else if (timer_q == TIMEOUT_LAST) begin
          state_d  = IDLE;
          err_to_d = 1'b1;
          tx_err_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      TX_WAIT: begin
        if (clk_s && data_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    clk_pd_d  = (state_d == TX_INHIBIT) || (state_d == TX_RTS);
    data_pd_d = (state_d == TX_RTS) || ((state_d == TX_DATA) && !tx_bit_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      rx_sr_q   <= '0;
      rx_par_q  <= 1'b0;
      tx_sr_q   <= '0;
      tx_bit_q  <= 1'b1;
      kb_pend_q <= 1'b0;
      clk_pd_q  <= 1'b0;
      data_pd_q <= 1'b0;
      tx_done_q <= 1'b0;
      tx_err_q  <= 1'b0;
      err_par_q <= 1'b0;
      err_frm_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      rx_sr_q   <= rx_sr_d;
      rx_par_q  <= rx_par_d;
      tx_sr_q   <= tx_sr_d;
      tx_bit_q  <= tx_bit_d;
      kb_pend_q <= kb_pend_d;
      clk_pd_q  <= clk_pd_d;
      data_pd_q <= data_pd_d;
      tx_done_q <= tx_done_d;
      tx_err_q  <= tx_err_d;
      err_par_q <= err_par_d;
      err_frm_q <= err_frm_d;
      err_to_q  <= err_to_d;
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign full = (count_q == DEPTH_C);
  assign pop  = rx_valid && rx_ready;
  assign push = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      if (push_req && !push) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= rx_sr_q;
  end

  assign rx_data           = mem[rd_ptr_q];
  assign rx_valid          = (count_q != '0);
  assign rx_count          = count_q;
  assign rx_overflow       = ovf_q;
  assign ps2_clk_pulldown  = clk_pd_q;
  assign ps2_data_pulldown = data_pd_q;
  assign tx_done           = tx_done_q;
  assign tx_err            = tx_err_q;
  assign err_parity        = err_par_q;
  assign err_frame         = err_frm_q;
  assign err_timeout       = err_to_q;
endmodule
